// File: rtl/wb_pipe_stage.sv
// Writeback stage: MEM/WB pipeline register, load lane extraction with sign/zero
// extension, four-way result select and a retired-instruction counter.
module wb_pipe_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallW,
    input  logic            flushW,
    input  logic            validM,
    input  logic            regwriteM,
    input  logic [1:0]      resultsrcM,
    input  logic [2:0]      funct3M,
    input  logic [XLEN-1:0] aluresultM,
    input  logic [XLEN-1:0] readdataM,
    input  logic [XLEN-1:0] pcplus4M,
    input  logic [XLEN-1:0] immextM,
    input  logic [REGW-1:0] rdM,
    output logic            validW,
    output logic            regwriteW,
    output logic [REGW-1:0] rdW,
    output logic [XLEN-1:0] resultW,
    output logic [CNTW-1:0] instretW
);

    localparam int OFFW = $clog2(XLEN / 8);
    localparam logic [OFFW-1:0] H_MASK = ~OFFW'(1);
    localparam logic [OFFW-1:0] W_MASK = ~OFFW'(3);

    logic            valid_q;
    logic            regwrite_q;
    logic [1:0]      resultsrc_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] aluresult_q;
    logic [XLEN-1:0] readdata_q;
    logic [XLEN-1:0] pcplus4_q;
    logic [XLEN-1:0] immext_q;
    logic [REGW-1:0] rd_q;
    logic [CNTW-1:0] instret_q;

    // Priority: rst > flush > stall > capture. Flush leaves the counter alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= '0;
            funct3_q    <= '0;
            aluresult_q <= '0;
            readdata_q  <= '0;
            pcplus4_q   <= '0;
            immext_q    <= '0;
            rd_q        <= '0;
            instret_q   <= '0;
        end else if (flushW) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= '0;
            funct3_q    <= '0;
            aluresult_q <= '0;
            readdata_q  <= '0;
            pcplus4_q   <= '0;
            immext_q    <= '0;
            rd_q        <= '0;
        end else if (!stallW) begin
            valid_q     <= validM;
            regwrite_q  <= regwriteM;
            resultsrc_q <= resultsrcM;
            funct3_q    <= funct3M;
            aluresult_q <= aluresultM;
            readdata_q  <= readdataM;
            pcplus4_q   <= pcplus4M;
            immext_q    <= immextM;
            rd_q        <= rdM;
            if (validM) begin
                instret_q <= instret_q + CNTW'(1);
            end
        end
    end

    logic [OFFW-1:0] off_b;
    logic [OFFW-1:0] off_h;
    logic [OFFW-1:0] off_w;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [31:0]     lane_w;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] result;

    // Halfword/word offsets are rounded down to their natural alignment.
    always_comb begin
        off_b  = aluresult_q[OFFW-1:0];
        off_h  = off_b & H_MASK;
        off_w  = off_b & W_MASK;
        lane_b = 8'(readdata_q >> {off_b, 3'b000});
        lane_h = 16'(readdata_q >> {off_h, 3'b000});
        lane_w = 32'(readdata_q >> {off_w, 3'b000});
    end

    always_comb begin
        load_data = readdata_q;
        case (funct3_q)
            3'b000:  load_data = XLEN'($signed(lane_b));
            3'b001:  load_data = XLEN'($signed(lane_h));
            3'b010:  load_data = XLEN'($signed(lane_w));
            3'b100:  load_data = XLEN'(lane_b);
            3'b101:  load_data = XLEN'(lane_h);
            3'b110:  load_data = (XLEN == 64) ? XLEN'(lane_w) : readdata_q;
            default: load_data = readdata_q;
        endcase
    end

    always_comb begin
        result = aluresult_q;
        case (resultsrc_q)
            2'b00:   result = aluresult_q;
            2'b01:   result = load_data;
            2'b10:   result = pcplus4_q;
            default: result = immext_q;
        endcase
    end

    assign validW    = valid_q;
    assign regwriteW = regwrite_q & valid_q & (rd_q != '0);
    assign rdW       = rd_q;
    assign resultW   = result;
    assign instretW  = instret_q;

endmodule

// File: doc/wb_pipe_stage.md
# wb_pipe_stage

Parametrised writeback stage: MEM/WB pipeline register, load-data lane extraction and sign/zero extension, four-source result select, and a retired-instruction counter. It sits between the memory stage and the register-file write port. It drives both the register-file write and the WB→EX forwarding path, and supports stall and flush from the hazard unit.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- REGW, 5, register-address width
- CNTW, 32, retired-instruction counter width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- stallW  in  1  hold the MEM/WB register contents
- flushW  in  1  load a bubble into the MEM/WB register
- validM  in  1  the memory-stage slot holds a real instruction
- regwriteM  in  1  the instruction writes the register file
- resultsrcM  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate (lui)
- funct3M  in  3  load type
- aluresultM  in  XLEN  ALU result; for loads this is the byte address
- readdataM  in  XLEN  naturally aligned XLEN-wide memory word
- pcplus4M  in  XLEN  PC+4
- immextM  in  XLEN  extended immediate
- rdM  in  REGW  destination register
- validW  out  1  the WB slot holds a real instruction
- regwriteW  out  1  register-file write enable, already qualified
- rdW  out  REGW  register-file write address
- resultW  out  XLEN  register-file write data and forwarding value
- instretW  out  CNTW  count of retired instructions

## Operation
- The register update priority is rst > flushW > stallW > load.
- **rst:** clear all registered fields to zero, including instretW.
- **flushW:** clear validW and the registered regwrite bit. The other fields are don't-care and are also cleared to zero.
- **stallW:** hold all fields and hold instretW.
- **Otherwise:** capture all M-side inputs.
- **regwriteW:** equals reg_regwrite & validW & (rdW != 0). Writes to x0 never leave the block.
- **Load extraction** works on the registered readdata. Lane offset = registered aluresult[log2(XLEN/8)-1:0], rounded down to the access size.
  - 000 lb: byte, sign-extended
  - 001 lh: halfword, sign-extended
  - 010 lw: word, sign-extended to XLEN
  - 100 lbu: byte, zero-extended
  - 101 lhu: halfword, zero-extended
  - 110 lwu: word, zero-extended; XLEN=64 only
  - 011 ld: full XLEN; XLEN=64 only
  - Any other code, or a 64-bit-only code when XLEN=32: pass readdata through unchanged.
- **resultW select**, by registered resultsrc: 00 aluresult, 01 extracted load, 10 pcplus4, 11 immext. It is combinational from registered state.
- **Retire counter:** instretW increments by 1 on each edge where a new entry with validM=1 is captured, i.e. not rst, not flushW, not stallW. It wraps from 2^CNTW−1 to 0.

## Timing
- Latency is 1 cycle: M-side inputs sampled at edge N appear on the W outputs after edge N.
- resultW is a combinational function of registered state only. It has no path from M-side inputs.
- instretW after edge N already includes the instruction captured at edge N.
- **Reset values:** validW=0, regwriteW=0, rdW=0, resultW=0 (resultsrc=00 with aluresult=0), instretW=0.
- **flushW and stallW together:** flush wins; the slot becomes a bubble.
- **rst in the middle of a stall:** all state clears; the stall has no effect on that edge.
- **Stall lasting several cycles:** outputs stay constant, and the held instruction counts once.
- **validM=0 captured without flush:** validW=0 and regwriteW=0; the counter does not increment.

## Test plan
- **Reset:** hold rst with arbitrary inputs → every output is 0 for all cycles while rst=1 and on the first cycle after release.
- **Load extension, XLEN=32:**
  - readdata=0x80FF7F01 with offset 1 → lb gives 0x0000007F, lbu gives 0x0000007F.
  - offset 2 → lb gives 0xFFFFFFFF, lbu gives 0x000000FF.
  - offset 2 → lh gives 0xFFFF80FF, lhu gives 0x000080FF.
- **Source select:** alu=0x11, pc4=0x22, imm=0x33 → resultsrc 00/10/11 give 0x11/0x22/0x33 one cycle later.
- **x0 suppression:** regwriteM=1, rdM=0, validM=1 → regwriteW=0 and instretW increments by 1.
- **Stall/flush:**
  - Capture an instruction, stall 3 cycles → outputs held and instretW +1 total.
  - Assert flushW and stallW together → validW=0 and regwriteW=0 next cycle.
- **Counter wrap, CNTW=4:** 17 valid captures → instretW=1; a bubble in between does not count.
